clock_reset_sequencer: RTL



---
 rtl/clock_reset_sequencer_if.sv | 40 ++++
 rtl/clock_reset_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/clock_reset_sequencer_if.sv
// Interface bundling the sequencer's PLL-side inputs and per-domain outputs.
//   pll_lock_async  raw PLL LOCKED, asynchronous to the reference clock
//   restart         single-cycle request to tear down and re-sequence
//   clk_en          per-domain BUFGCE clock enables
//   domain_rst_n    per-domain active-low resets, released in index order
//   ready           all domains released and running
//   lock_lost_count saturating count of lock-loss events
//   lock_timeout    sticky lock watchdog flag
// master: the sequencer. slave: the consumer of enables/resets that also drives the inputs.
interface clock_reset_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = 3
);
  logic                   pll_lock_async;
  logic                   restart;
  logic [NUM_DOMAINS-1:0] clk_en;
  logic [NUM_DOMAINS-1:0] domain_rst_n;
  logic                   ready;
  logic [7:0]             lock_lost_count;
  logic                   lock_timeout;

  modport master (
    input  pll_lock_async,
    input  restart,
    output clk_en,
    output domain_rst_n,
    output ready,
    output lock_lost_count,
    output lock_timeout
  );

  modport slave (
    output pll_lock_async,
    output restart,
    input  clk_en,
    input  domain_rst_n,
    input  ready,
    input  lock_lost_count,
    input  lock_timeout
  );
endinterface

// File: rtl/clock_reset_sequencer.sv
// Clock/reset sequencer running on the free-running reference clock ahead of the PLL.
// Synchronises PLL lock, debounces it, enables all domain clocks, then releases the domain
// resets one at a time in index order. Loss of lock or a restart request tears everything
// down for one cycle and the sequence starts over; lock losses are counted (saturating).
// Ports:
//   clk_i   free-running reference clock
//   rst_ni  synchronous active-low reset
//   bus     clock_reset_sequencer_if.master (lock/restart in, enables/resets/status out)
// Optional build macro CLKSEQ_LOCK_WATCHDOG_EN adds a watchdog that sets the sticky
// lock_timeout flag after TIMEOUT cycles spent waiting for lock; otherwise it is tied to 0.
module clock_reset_sequencer #(
  parameter int unsigned NUM_DOMAINS   = 3,
  parameter int unsigned LOCK_DEBOUNCE = 1024,
  parameter int unsigned STAGE_DELAY   = 256,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned TIMEOUT       = 65535
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  clock_reset_sequencer_if.master bus
);

  localparam int unsigned IdxW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_WIDTH-1:0] DebLast   = CNT_WIDTH'(LOCK_DEBOUNCE - 1);
  localparam logic [CNT_WIDTH-1:0] StageLast = CNT_WIDTH'(STAGE_DELAY - 1);
  localparam logic [IdxW-1:0]      IdxLast   = IdxW'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    StWaitLock,
    StClkOn,
    StRelease,
    StRun,
    StTeardown
  } state_e;

  logic [1:0]             sync_q;
  logic                   lock_s;
  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [IdxW-1:0]        idx_q;
  logic [NUM_DOMAINS-1:0] clk_en_q;
  logic [NUM_DOMAINS-1:0] dom_rst_n_q;
  logic                   ready_q;
  logic [7:0]             lost_cnt_q;

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.pll_lock_async};
    end
  end

  assign lock_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StWaitLock;
      cnt_q       <= '0;
      idx_q       <= '0;
      clk_en_q    <= '0;
      dom_rst_n_q <= '0;
      ready_q     <= 1'b0;
      lost_cnt_q  <= '0;
    end else begin
      case (state_q)
        StWaitLock: begin
          if (bus.restart || !lock_s) begin
            cnt_q <= '0;
          end else if (cnt_q == DebLast) begin
            state_q  <= StClkOn;
            cnt_q    <= '0;
            clk_en_q <= '1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StClkOn, StRelease, StRun: begin
          if (!lock_s || bus.restart) begin
            state_q     <= StTeardown;
            cnt_q       <= '0;
            idx_q       <= '0;
            clk_en_q    <= '0;
            dom_rst_n_q <= '0;
            ready_q     <= 1'b0;
            // A simultaneous restart and lock loss counts once, as a lock loss.
            if (!lock_s && lost_cnt_q != 8'hFF) begin
              lost_cnt_q <= lost_cnt_q + 8'd1;
            end
          end else if (state_q == StClkOn) begin
            if (cnt_q == StageLast) begin
              state_q <= StRelease;
              cnt_q   <= '0;
              idx_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (state_q == StRelease) begin
            if (cnt_q == StageLast) begin
              dom_rst_n_q[idx_q] <= 1'b1;
              cnt_q              <= '0;
              if (idx_q == IdxLast) begin
                state_q <= StRun;
                ready_q <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        StTeardown: state_q <= StWaitLock;

        default: state_q <= StWaitLock;
      endcase
    end
  end

  assign bus.clk_en          = clk_en_q;
  assign bus.domain_rst_n    = dom_rst_n_q;
  assign bus.ready           = ready_q;
  assign bus.lock_lost_count = lost_cnt_q;

`ifdef CLKSEQ_LOCK_WATCHDOG_EN
  localparam logic [CNT_WIDTH-1:0] WdLast = CNT_WIDTH'(TIMEOUT - 1);

  logic [CNT_WIDTH-1:0] wd_q;
  logic                 timeout_q;

  // Counts only while waiting for lock; the counter parks at its limit, the flag is sticky.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == StWaitLock) begin
      if (wd_q == WdLast) begin
        timeout_q <= 1'b1;
      end else begin
        wd_q <= wd_q + 1'b1;
      end
    end else begin
      wd_q <= '0;
    end
  end

  assign bus.lock_timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout   = ^TIMEOUT;
  assign bus.lock_timeout = 1'b0;
`endif

endmodule
